// File: rtl/ram_io.sv
// Parametrised single-port bus RAM with a synchronised button capture slot,
// a post-reset zero sweep and an asynchronous display read port.
module ram_io #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int IN_WIDTH       = 1,
  parameter int INPUT_ADDR     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic                  oe,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  busy,
  output logic                  in_flag,
  input  logic                  btn_strobe,
  input  logic [IN_WIDTH-1:0]   btn_value,
  input  logic [ADDR_WIDTH-1:0] disp_addr,
  output logic [DATA_WIDTH-1:0] disp_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] IN_ADDR   = ADDR_WIDTH'(INPUT_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t                  state, next_state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_buf;
  logic                    clear_we;

  logic                    s1_strobe, s2_strobe, s3_strobe;
  logic [IN_WIDTH-1:0]     s1_val, s2_val;
  logic                    pend;
  logic [DATA_WIDTH-1:0]   cap_val;

  logic                    btn_edge, cap_req, conflict, commit;
  logic [DATA_WIDTH-1:0]   cap_data;
  logic                    cpu_rd, drive;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
    else        state <= next_state;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    if (state == ST_CLEAR && clr_cnt == LAST_ADDR) next_state = ST_IDLE;
  end

  always_comb begin
    busy     = 1'b0;
    clear_we = 1'b0;
    if (state == ST_CLEAR) begin
      busy     = 1'b1;
      clear_we = 1'b1;
    end
  end

  // The sweep counter parks on the last word; only reset brings it back to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              clr_cnt <= '0;
    else if (busy && clr_cnt != LAST_ADDR)  clr_cnt <= clr_cnt + 1'b1;
  end

  assign btn_edge = s2_strobe & ~s3_strobe;
  assign cap_req  = btn_edge | pend;
  assign cap_data = btn_edge ? DATA_WIDTH'(s2_val) : cap_val;
  assign conflict = busy | (we & (addr == IN_ADDR));
  assign commit   = cap_req & ~conflict;
  assign cpu_rd   = ~we & ~busy;
  assign drive    = oe & ~we & ~busy;

  // NOTE: the array has no reset; contents are defined only by the clear sweep
  // and writes, which keeps it mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (clear_we)  mem[clr_cnt] <= '0;
    else if (we)   mem[addr]    <= data;
    if (commit)    mem[IN_ADDR] <= cap_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rd_buf <= '0;
    else if (cpu_rd) rd_buf <= mem[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_strobe <= 1'b0;
      s2_strobe <= 1'b0;
      s3_strobe <= 1'b0;
      s1_val    <= '0;
      s2_val    <= '0;
    end else begin
      s1_strobe <= btn_strobe;
      s2_strobe <= s1_strobe;
      s3_strobe <= s2_strobe;
      s1_val    <= btn_value;
      s2_val    <= s1_val;
    end
  end

  // A blocked capture parks in cap_val; a newer edge overwrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= 1'b0;
      cap_val <= '0;
    end else if (commit) begin
      pend    <= 1'b0;
    end else if (cap_req) begin
      pend    <= 1'b1;
      if (btn_edge) cap_val <= DATA_WIDTH'(s2_val);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  in_flag <= 1'b0;
    else if (commit)                             in_flag <= 1'b1;
    else if (cpu_rd && oe && addr == IN_ADDR)    in_flag <= 1'b0;
  end

  assign data      = drive ? rd_buf : 'z;
  assign disp_data = mem[disp_addr];

endmodule

// File: tb/tb_ram_io.sv
// Directed bench for ram_io: clear sweep, bus read/write, button capture,
// capture conflicts and reset mid-sweep, with a scoreboard for bus reads.
module tb_ram_io;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          we = 1'b0;
  logic          oe = 1'b0;
  wire  [DW-1:0] data;
  logic [DW-1:0] bus_drv = '0;
  logic          bus_en = 1'b0;
  logic          busy, in_flag;
  logic          btn_strobe = 1'b0;
  logic [0:0]    btn_value = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] disp_data;

  assign data = bus_en ? bus_drv : 'z;

  ram_io #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IN_WIDTH(1),
    .INPUT_ADDR(0), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .we(we), .oe(oe), .data(data),
    .busy(busy), .in_flag(in_flag), .btn_strobe(btn_strobe),
    .btn_value(btn_value), .disp_addr(disp_addr), .disp_data(disp_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string         tag;
    logic [DW-1:0] val;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A released bus reads as Z on 4-state simulators and as 0 on 2-state ones.
  task automatic check_float(input string tag);
    logic [DW-1:0] obs;
    obs = data;
    checks++;
    assert ((obs === 8'hzz) || (obs === 8'h00)) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=high-Z", tag, obs);
    end
  endtask

  task automatic check_mem(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    disp_addr = a;
    #1;
    check(tag, disp_data, exp);
  endtask

  task automatic expect_read(input string tag, input logic [DW-1:0] val);
    sb.push_back('{tag, val});
  endtask

  task automatic pop_read();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty: observed=%h expected=queued read", data);
    end else begin
      e = sb.pop_front();
      check(e.tag, data, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) dut.mem[i] = 8'hFF;

    // Clear sweep after reset with preloaded contents
    @(negedge clk);
    check("rst_busy", {7'd0, busy}, 8'd1);
    check("rst_in_flag", {7'd0, in_flag}, 8'd0);
    oe = 1'b1;
    #1 check_float("rst_bus");
    rst_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      check($sformatf("sweep_busy_%0d", e), {7'd0, busy}, (e < 16) ? 8'd1 : 8'd0);
      if (e == 1) begin
        check_float("busy_bus");
        check_mem("sweep_untouched", 4'd15, 8'hFF);
      end
      if (e == 8) begin
        check_mem("sweep_done7", 4'd7, 8'h00);
        check_mem("sweep_todo8", 4'd8, 8'hFF);
      end
    end
    oe = 1'b0;
    for (int i = 0; i < 16; i++) check_mem($sformatf("swept_%0d", i), 4'(i), 8'h00);
    @(negedge clk);

    // CPU write and read with bus direction
    we = 1'b1; addr = 4'd3; bus_en = 1'b1; bus_drv = 8'hA5;
    tick();
    check_mem("wr_visible", 4'd3, 8'hA5);
    we = 1'b0; bus_en = 1'b0; oe = 1'b1;
    expect_read("rd_a5", 8'hA5);
    tick();
    pop_read();
    oe = 1'b0;
    #1 check_float("oe0_float");
    oe = 1'b1; we = 1'b1; addr = 4'd4; bus_en = 1'b1; bus_drv = 8'h5A;
    #1 check("we1_no_drive", data, 8'h5A);
    tick();
    check_mem("wr4", 4'd4, 8'h5A);
    we = 1'b0; bus_en = 1'b0; oe = 1'b0;

    // Button capture with a held strobe
    btn_value = 1'b1; btn_strobe = 1'b1;
    tick();
    check("cap_k_flag", {7'd0, in_flag}, 8'd0);
    tick();
    check("cap_k1_flag", {7'd0, in_flag}, 8'd0);
    check_mem("cap_early", 4'd0, 8'h00);
    tick();
    check("cap_k2_flag", {7'd0, in_flag}, 8'd1);
    check_mem("cap_commit", 4'd0, 8'h01);
    we = 1'b1; addr = 4'd0; bus_en = 1'b1; bus_drv = 8'h77;
    tick();
    we = 1'b0; bus_en = 1'b0;
    check_mem("cpu_over_cap", 4'd0, 8'h77);
    tick();
    btn_strobe = 1'b0;
    tick(); tick(); tick();
    check_mem("one_commit", 4'd0, 8'h77);
    check("flag_sticky", {7'd0, in_flag}, 8'd1);
    oe = 1'b1; addr = 4'd0;
    expect_read("rd_input", 8'h77);
    tick();
    pop_read();
    check("flag_cleared", {7'd0, in_flag}, 8'd0);
    oe = 1'b0;

    // Capture colliding with a CPU write to the input slot
    btn_strobe = 1'b1;
    tick();
    btn_strobe = 1'b0;
    tick();
    we = 1'b1; addr = 4'd0; bus_en = 1'b1; bus_drv = 8'h3C;
    tick();
    we = 1'b0; bus_en = 1'b0;
    check_mem("conflict_cpu", 4'd0, 8'h3C);
    check("conflict_flag0", {7'd0, in_flag}, 8'd0);
    tick();
    check_mem("conflict_cap", 4'd0, 8'h01);
    check("conflict_flag1", {7'd0, in_flag}, 8'd1);

    // Reset mid-sweep, then capture during the restarted sweep
    rst_n = 1'b0;
    #1;
    check("rst2_flag", {7'd0, in_flag}, 8'd0);
    check("rst2_busy", {7'd0, busy}, 8'd1);
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) tick();
    check("mid_busy", {7'd0, busy}, 8'd1);
    rst_n = 1'b0;
    #1 check("mid_rst_busy", {7'd0, busy}, 8'd1);
    dut.mem[2] = 8'hFF;
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      check($sformatf("restart_busy_%0d", e), {7'd0, busy}, (e < 16) ? 8'd1 : 8'd0);
      if (e == 1) btn_strobe = 1'b1;
      if (e == 2) btn_strobe = 1'b0;
      if (e == 3) check_mem("restart_addr2", 4'd2, 8'h00);
    end
    check_mem("pend_hold", 4'd0, 8'h00);
    check("pend_flag0", {7'd0, in_flag}, 8'd0);
    oe = 1'b1; addr = 4'd0;
    expect_read("rd_old", 8'h00);
    tick();
    pop_read();
    check("set_wins", {7'd0, in_flag}, 8'd1);
    check_mem("pend_commit", 4'd0, 8'h01);
    expect_read("rd_new", 8'h01);
    tick();
    pop_read();
    check("flag_clear2", {7'd0, in_flag}, 8'd0);
    oe = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
